// File: rtl/vout_pkg.sv
// Shared types and helpers for the video output alignment stage.
// RGB565/RGB888 pixel layouts, FSM state enum, and the colour expander.
// VOUT_BIT_REPLICATE_EN selects MSB-replication expansion; otherwise zero-fill.
package vout_pkg;

  localparam int R5_W = 5;
  localparam int G6_W = 6;
  localparam int B5_W = 5;
  localparam int C8_W = 8;

  typedef enum logic {
    S_WAIT_VS = 1'b0,
    S_RUN     = 1'b1
  } vout_state_e;

  typedef struct packed {
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [C8_W-1:0] r;
    logic [C8_W-1:0] g;
    logic [C8_W-1:0] b;
  } rgb888_t;

  // Widen each colour channel to 8 bits.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] px);
    rgb565_t p;
    rgb888_t o;
    p = rgb565_t'(px);
`ifdef VOUT_BIT_REPLICATE_EN
    // Replicating the MSBs makes full-scale inputs map to full-scale outputs.
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
`else
    o.r = {p.r, 3'b000};
    o.g = {p.g, 2'b00};
    o.b = {p.b, 3'b000};
`endif
    return o;
  endfunction

endpackage

// File: rtl/vout_sync_dly.sv
// N-stage shift register for HS/VS/DE from the sync generator.
// Latency: N cycles (tap N). No backpressure; advances every pixel clock.
// Synchronous reset loads the inactive sync level so no false edge leaves the chain.
module vout_sync_dly #(
  parameter int N = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pol_i,
  input  logic vs_i,
  input  logic hs_i,
  input  logic de_i,
  output logic vs_o,
  output logic hs_o,
  output logic de_o
);

  logic [N-1:0] vs_q;
  logic [N-1:0] hs_q;
  logic [N-1:0] de_q;

  // Shift the three sync lines one stage per pixel clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q <= {N{~pol_i}};
      hs_q <= {N{~pol_i}};
      de_q <= '0;
    end else begin
      vs_q <= {vs_q[N-2:0], vs_i};
      hs_q <= {hs_q[N-2:0], hs_i};
      de_q <= {de_q[N-2:0], de_i};
    end
  end

  assign vs_o = vs_q[N-1];
  assign hs_o = hs_q[N-1];
  assign de_o = de_q[N-1];

endmodule

// File: rtl/vout_pixel_align.sv
// Aligns delayed HS/VS/DE with frame-buffer data, expands RGB565->RGB888, fills underflow.
// Latency: sync SYNC_DLY+1 cycles, data 1 cycle. No backpressure: one pixel per clock.
// Locks on a VS leading edge; stray data in blanking drops lock. VOUT_BIT_REPLICATE_EN picks expansion.
module vout_pixel_align
  import vout_pkg::*;
#(
  parameter int          SYNC_DLY = 5,
  parameter logic [23:0] BG_COLOR = 24'h0000FF,
  parameter int          CNT_W    = 16
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic             I_vs_pol,
  input  logic             I_vs,
  input  logic             I_hs,
  input  logic             I_de,
  input  logic             I_fb_den,
  input  logic [15:0]      I_fb_data,
  output logic             O_vs,
  output logic             O_hs,
  output logic             O_de,
  output logic [7:0]       O_rgb_r,
  output logic [7:0]       O_rgb_g,
  output logic [7:0]       O_rgb_b,
  output logic             O_locked,
  output logic             O_underflow,
  output logic [CNT_W-1:0] O_underflow_cnt,
  output logic [CNT_W-1:0] O_frame_cnt
);

  logic sd_vs, sd_hs, sd_de;

  vout_sync_dly #(.N(SYNC_DLY)) u_sync_dly (
    .clk_i (I_pxl_clk),
    .rst_i (I_rst),
    .pol_i (I_vs_pol),
    .vs_i  (I_vs),
    .hs_i  (I_hs),
    .de_i  (I_de),
    .vs_o  (sd_vs),
    .hs_o  (sd_hs),
    .de_o  (sd_de)
  );

  vout_state_e      state_q;
  logic             vs_act_q;
  logic             vs_q, hs_q, de_q;
  rgb888_t          rgb_q;
  logic             locked_q;
  logic             uf_q;
  logic [CNT_W-1:0] uf_cnt_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic             vs_act, vs_lead, stray;
  logic [CNT_W-1:0] uf_cnt_d;
  logic [CNT_W-1:0] frame_cnt_d;

  assign vs_act  = ~(sd_vs ^ I_vs_pol);
  assign vs_lead = vs_act & ~vs_act_q;
  // Data valid outside active video means the read side is out of step.
  assign stray   = ~sd_de & I_fb_den;

  // Saturating underflow count and wrapping frame count.
  always_comb begin
    uf_cnt_d    = (&uf_cnt_q) ? uf_cnt_q : uf_cnt_q + CNT_W'(1);
    frame_cnt_d = frame_cnt_q + CNT_W'(1);
  end

  // Lock FSM plus every registered output.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      state_q     <= S_WAIT_VS;
      vs_act_q    <= 1'b0;
      vs_q        <= ~I_vs_pol;
      hs_q        <= ~I_vs_pol;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      locked_q    <= 1'b0;
      uf_q        <= 1'b0;
      uf_cnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      vs_act_q <= vs_act;
      vs_q     <= sd_vs;
      hs_q     <= sd_hs;
      de_q     <= 1'b0;
      rgb_q    <= '0;
      case (state_q)
        S_WAIT_VS: begin
          if (vs_lead) begin
            state_q  <= S_RUN;
            locked_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (stray) begin
            // Blank this cycle and wait for a fresh frame start.
            state_q  <= S_WAIT_VS;
            locked_q <= 1'b0;
          end else begin
            de_q <= sd_de;
            if (vs_lead) frame_cnt_q <= frame_cnt_d;
            if (sd_de) begin
              if (I_fb_den) begin
                rgb_q <= rgb565_to_888(I_fb_data);
              end else begin
                rgb_q    <= rgb888_t'(BG_COLOR);
                uf_q     <= 1'b1;
                uf_cnt_q <= uf_cnt_d;
              end
            end
          end
        end
        default: begin
          state_q  <= S_WAIT_VS;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_vs            = vs_q;
  assign O_hs            = hs_q;
  assign O_de            = de_q;
  assign O_rgb_r         = rgb_q.r;
  assign O_rgb_g         = rgb_q.g;
  assign O_rgb_b         = rgb_q.b;
  assign O_locked        = locked_q;
  assign O_underflow     = uf_q;
  assign O_underflow_cnt = uf_cnt_q;
  assign O_frame_cnt     = frame_cnt_q;

endmodule

// File: doc/vout_pixel_align.md
Name: vout_pixel_align

Overview:
Output-side alignment stage between the frame buffer read port / sync generator and the DVI TX.
- Delays the sync generator's HS/VS/DE to line up with frame-buffer read data.
- Expands RGB565 to RGB888.
- Substitutes a background colour on underflow.
- Tracks lock, frame count and underflow statistics in the pixel clock domain.

Parameters:
SYNC_DLY, 5, pipeline stages applied to HS/VS/DE before they meet I_fb_den/I_fb_data (2..16)
BG_COLOR, 24'h0000FF, {r,g,b} driven on underflow pixels
CNT_W, 16, width of frame and underflow counters

Ports:
I_pxl_clk  in  1  pixel clock
I_rst  in  1  reset, synchronous, active-high
I_vs_pol  in  1  VS/HS polarity: 1 = active-high, 0 = active-low (static)
I_vs  in  1  VS from sync generator
I_hs  in  1  HS from sync generator
I_de  in  1  DE from sync generator
I_fb_den  in  1  frame buffer read-data valid
I_fb_data  in  16  frame buffer read data, RGB565 {r[4:0],g[5:0],b[4:0]}
O_vs  out  1  aligned VS
O_hs  out  1  aligned HS
O_de  out  1  aligned DE
O_rgb_r  out  8  red
O_rgb_g  out  8  green
O_rgb_b  out  8  blue
O_locked  out  1  1 while in S_RUN
O_underflow  out  1  sticky: an underflow pixel has occurred since reset
O_underflow_cnt  out  CNT_W  underflow pixel count, saturating
O_frame_cnt  out  CNT_W  frames output while locked, wrapping

Behaviour:
- Single clock I_pxl_clk. Reset synchronous, active-high: all state is updated on the I_pxl_clk edge where I_rst=1.
- Reset values:
  - Sync pipeline stages and O_vs/O_hs = inactive level (~I_vs_pol).
  - O_de=0; O_rgb_*=0; O_locked=0; O_underflow=0; both counters=0; state=S_WAIT_VS.
- Pipeline: sd_* = tap SYNC_DLY of the HS/VS/DE shift registers. sd_* meets I_fb_den/I_fb_data in the same cycle, then passes through one output register.
  - Sync latency: SYNC_DLY+1 cycles. Data latency: 1 cycle.
- vs_act = sd_vs XNOR I_vs_pol. vs_lead = vs_act & ~vs_act_d (registered previous value).
- State S_WAIT_VS:
  - O_vs/O_hs follow the pipeline; O_de=0; O_rgb=0; nothing counted.
  - On vs_lead -> S_RUN.
- State S_RUN:
  - O_de = sd_de.
  - sd_de=1 and I_fb_den=1: O_rgb = expand(I_fb_data).
  - sd_de=1 and I_fb_den=0 (underflow): O_rgb=BG_COLOR; O_underflow<=1; O_underflow_cnt += 1, saturating at all-ones.
  - sd_de=0: O_rgb=0.
  - sd_de=0 and I_fb_den=1 (stray data, misalignment) -> S_WAIT_VS next cycle. The output for that cycle stays blank.
  - vs_lead in S_RUN: O_frame_cnt += 1, wraps to 0.
- Stray data and underflow are mutually exclusive by definition.
- vs_lead in the same cycle as stray data: the stray-data transition wins; frame_cnt is not incremented.
- O_locked = (state==S_RUN), registered alongside the outputs.
- Reset mid-frame: outputs blank and return to reset values at that edge. The block relocks only on the next full vs_lead after I_rst deasserts.
- I_vs_pol change while running: undefined. It is static by contract.

Optional Feature:
Macro VOUT_BIT_REPLICATE_EN.
- Defined: expand by MSB replication: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}. 5'h1F -> 8'hFF.
- Undefined: zero-fill: {r5,3'b0},{g6,2'b0},{b5,3'b0}. 5'h1F -> 8'hF8.

Decomposition:
- Shared package vout_pkg:
  - state enum {S_WAIT_VS,S_RUN}
  - RGB565/RGB888 field widths
  - function rgb565_to_888 (the macro selects its body)
- Sub-module vout_sync_dly: parameterised N-stage HS/VS/DE shift register with polarity-aware synchronous reset. It holds the sd_* taps.

Test Plan:
1. Reset, then pol=1, SYNC_DLY=5, generator timing 16x4 active with full den aligned.
   -> O_locked=1 after the first VS leading edge.
   -> O_vs lags I_vs by 6 cycles; O_de lags I_de by 6.
   -> O_frame_cnt=3 after 3 further frames.
2. Data 16'hF800 aligned in S_RUN.
   -> O_rgb=FF,00,00 with macro; F8,00,00 without.
3. Drop I_fb_den for 7 pixels inside one active line.
   -> those 7 outputs = 00,00,FF; O_underflow=1; O_underflow_cnt=7; O_locked stays 1.
4. Assert I_fb_den for 1 cycle during blanking (sd_de=0).
   -> O_locked=0 next cycle, O_de=0 until the next VS leading edge, then relock; frame_cnt not incremented on the erroneous cycle.
5. CNT_W=4 and 20 underflow pixels.
   -> O_underflow_cnt saturates at 4'hF. Then 17 locked frames -> O_frame_cnt wraps to 1.
6. pol=0, assert I_rst mid-line for 1 cycle.
   -> next cycle O_vs=O_hs=1, O_de=0, counters=0, O_locked=0; relock after the next low-going VS edge.
